// File: rtl/mc_cu.sv
// Multi-cycle control unit: sequences a shared ALU and unified memory through IF/ID/EXE/MEM/WB,
// with a memory-ready handshake and a sticky wait-timeout flag.
//
// state | meaning
// IF    | fetch at PC, PC+4 into PC when memory is ready
// ID    | decode, branch target into ALUOut, resolve jumps
// EXE   | ALU operation, address calc or branch compare
// MEM   | data access at ALUOut
// WB    | register-file write
module mc_cu #(
    parameter int MEM_HS   = 1,
    parameter int MAX_WAIT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t     cur, nxt;
    logic [7:0] wait_cnt;
    logic       ready, waiting, timeout;
    logic       wpc_c, wir_c, wmem_c, wreg_c;

    logic r_type, r_add, r_sub, r_and, r_or, r_xor, r_sll, r_srl, r_sra, r_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic alu_r, is_imm, valid;
    logic [3:0] r_aluc, imm_aluc;

    assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

    assign r_type = (op == 6'b000000);
    assign r_add  = r_type && (func == 6'b100000);
    assign r_sub  = r_type && (func == 6'b100010);
    assign r_and  = r_type && (func == 6'b100100);
    assign r_or   = r_type && (func == 6'b100101);
    assign r_xor  = r_type && (func == 6'b100110);
    assign r_sll  = r_type && (func == 6'b000000);
    assign r_srl  = r_type && (func == 6'b000010);
    assign r_sra  = r_type && (func == 6'b000011);
    assign r_jr   = r_type && (func == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign alu_r  = r_add | r_sub | r_and | r_or | r_xor | r_sll | r_srl | r_sra;
    assign is_imm = i_addi | i_andi | i_ori | i_xori;
    assign valid  = alu_r | r_jr | is_imm | i_lui | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

    always_comb begin
        r_aluc = ALU_ADD;
        case (func)
            6'b100010: r_aluc = ALU_SUB;
            6'b100100: r_aluc = ALU_AND;
            6'b100101: r_aluc = ALU_OR;
            6'b100110: r_aluc = ALU_XOR;
            6'b000000: r_aluc = ALU_SLL;
            6'b000010: r_aluc = ALU_SRL;
            6'b000011: r_aluc = ALU_SRA;
            default:   r_aluc = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_aluc = ALU_ADD;
        if (i_andi)      imm_aluc = ALU_AND;
        else if (i_ori)  imm_aluc = ALU_OR;
        else if (i_xori) imm_aluc = ALU_XOR;
    end

    // Completion on the final permitted cycle beats the timeout.
    assign waiting = ((cur == S_IF) || (cur == S_MEM)) && !ready;
    assign timeout = waiting && (wait_cnt == MAX_CNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur      <= S_IF;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            cur <= nxt;
            if (timeout) begin
                mem_err  <= 1'b1;
                wait_cnt <= 8'd0;
            end else if (nxt != cur) begin
                wait_cnt <= 8'd0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        nxt      = cur;
        wpc_c    = 1'b0;
        wir_c    = 1'b0;
        wmem_c   = 1'b0;
        wreg_c   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = ALU_ADD;
        pcsource = 2'b00;
        case (cur)
            S_IF: begin
                alusrcb = 2'b01;
                if (ready) begin
                    wpc_c = 1'b1;
                    wir_c = 1'b1;
                    nxt   = S_ID;
                end
            end
            S_ID: begin
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (i_j || i_jal) begin
                    wpc_c    = 1'b1;
                    pcsource = 2'b11;
                    wreg_c   = i_jal;
                    jal      = i_jal;
                    nxt      = S_IF;
                end else if (r_jr) begin
                    wpc_c    = 1'b1;
                    pcsource = 2'b10;
                    nxt      = S_IF;
                end else if (!valid) begin
                    nxt = S_IF;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                if (alu_r) begin
                    alusrca = 1'b1;
                    shift   = r_sll | r_srl | r_sra;
                    aluc    = r_aluc;
                    nxt     = S_WB;
                end else if (is_imm) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    sext    = i_addi;
                    aluc    = imm_aluc;
                    nxt     = S_WB;
                end else if (i_lui) begin
                    alusrcb = 2'b10;
                    aluc    = ALU_LUI;
                    nxt     = S_WB;
                end else if (i_lw || i_sw) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    sext    = 1'b1;
                    nxt     = S_MEM;
                end else if (i_beq || i_bne) begin
                    alusrca = 1'b1;
                    aluc    = ALU_SUB;
                    nxt     = S_IF;
                    if ((i_beq && z) || (i_bne && !z)) begin
                        wpc_c    = 1'b1;
                        pcsource = 2'b01;
                    end
                end else begin
                    nxt = S_IF;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                wmem_c = i_sw && !timeout;
                if (ready)        nxt = i_lw ? S_WB : S_IF;
                else if (timeout) nxt = S_IF;
            end
            S_WB: begin
                wreg_c = 1'b1;
                regrt  = is_imm | i_lui | i_lw;
                m2reg  = i_lw;
                nxt    = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

    // Strobes are killed combinationally so a reset pulse stops writes without a clock edge.
    assign wpc   = wpc_c  & ~reset;
    assign wir   = wir_c  & ~reset;
    assign wmem  = wmem_c & ~reset;
    assign wreg  = wreg_c & ~reset;
    assign state = cur;

endmodule
